// File: rtl/vga_pkg.sv
// VGA timing package: default 640x480@60 timing, colour-bar table and
// the region type shared by the horizontal and vertical decoders.
package vga_pkg;

   localparam int unsigned DEF_CLK_DIV  = 2;
   localparam int unsigned DEF_CNT_W    = 10;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned NUM_BARS     = 8;

   // Left-to-right bar order; index 0 is the leftmost bar.
   localparam logic [0:7][23:0] BAR_RGB = {
      24'hFFFFFF,
      24'hFFFF00,
      24'h00FFFF,
      24'h00FF00,
      24'hFF00FF,
      24'hFF0000,
      24'h0000FF,
      24'h000000
   };

   typedef enum logic [1:0] {
      ACTIVE,
      FP,
      SYNC,
      BP
   } region_t;

   function automatic region_t get_region(
      input int unsigned pos,
      input int unsigned act,
      input int unsigned fp,
      input int unsigned sync
   );
      if (pos < act)
         return ACTIVE;
      else if (pos < act + fp)
         return FP;
      else if (pos < act + fp + sync)
         return SYNC;
      else
         return BP;
   endfunction

endpackage

// File: rtl/vga_ce_div.sv
// Pixel clock-enable divider: one registered pix_ce every CLK_DIV clocks,
// phase held while en is low.
module vga_ce_div #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick,
   output logic pix_ce
);

   localparam int unsigned DW =
      (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   // tick is the wrap cycle; the timing core advances on it so that
   // its registers change on the same edge that raises pix_ce.
   assign tick = en && (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         pix_ce  <= 1'b0;
      end else begin
         pix_ce <= tick;
         if (en)
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator on a single clock with pixel enable.
// Define VGA_TEST_PATTERN_EN to drive 8 colour bars on rgb_o.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0
) (
   input  logic             clk,
   input  logic             rstBtn,
   input  logic             en,
   output logic             pix_ce,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             blank_n_o,
   output logic             sync_n_o,
   output logic             line_start_o,
   output logic             frame_start_o,
   output logic [23:0]      rgb_o
);

   localparam int unsigned H_TOTAL =
      H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL =
      V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic             tick;
   logic [CNT_W-1:0] x_nxt;
   logic [CNT_W-1:0] y_nxt;
   region_t          h_rgn;
   region_t          v_rgn;
   logic             blank_nxt;

   vga_ce_div #(
      .CLK_DIV (CLK_DIV)
   ) u_ce_div (
      .clk    (clk),
      .rst_n  (rstBtn),
      .en     (en),
      .tick   (tick),
      .pix_ce (pix_ce)
   );

   always_comb begin
      x_nxt = x_o + 1'b1;
      y_nxt = y_o;
      if (x_o == H_LAST) begin
         x_nxt = '0;
         y_nxt = (y_o == V_LAST) ? '0 : y_o + 1'b1;
      end
   end

   // Regions decode the next position so registered outputs line up
   // with the counters presented on the same cycle.
   assign h_rgn = get_region(32'(x_nxt), H_ACTIVE, H_FP, H_SYNC);
   assign v_rgn = get_region(32'(y_nxt), V_ACTIVE, V_FP, V_SYNC);

   assign blank_nxt = (h_rgn == ACTIVE) && (v_rgn == ACTIVE);

   assign sync_n_o = 1'b0;

   always_ff @(posedge clk or negedge rstBtn) begin
      if (!rstBtn) begin
         x_o           <= H_LAST;
         y_o           <= V_LAST;
         blank_n_o     <= 1'b0;
         hsync_o       <= ~H_POL;
         vsync_o       <= ~V_POL;
         line_start_o  <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         line_start_o  <= 1'b0;
         frame_start_o <= 1'b0;
         if (tick) begin
            x_o           <= x_nxt;
            y_o           <= y_nxt;
            blank_n_o     <= blank_nxt;
            hsync_o       <= (h_rgn == SYNC) ? H_POL : ~H_POL;
            vsync_o       <= (v_rgn == SYNC) ? V_POL : ~V_POL;
            line_start_o  <= (x_nxt == '0);
            frame_start_o <= (x_nxt == '0) && (y_nxt == '0);
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W =
      (H_ACTIVE >= NUM_BARS) ? H_ACTIVE / NUM_BARS : 1;

   logic [31:0] bar_q;
   logic [2:0]  bar_idx;
   logic [23:0] rgb_nxt;

   always_comb begin
      bar_q   = 32'(x_nxt) / BAR_W;
      bar_idx = (bar_q > 32'd7) ? 3'd7 : bar_q[2:0];
      rgb_nxt = blank_nxt ? BAR_RGB[bar_idx] : 24'h0;
   end

   always_ff @(posedge clk or negedge rstBtn) begin
      if (!rstBtn)
         rgb_o <= 24'h0;
      else if (tick)
         rgb_o <= rgb_nxt;
   end
`else
   assign rgb_o = 24'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line/enable behaviour and
// a tiny-timing instance (CLK_DIV=1, H_POL=1) for frame, reset and bars.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, en0, ce0, hs0, vs0, bl0, sn0, ls0, fs0;
   logic [9:0] x0, y0;
   logic [23:0] rgb0;

   logic       rst1, en1, ce1, hs1, vs1, bl1, sn1, ls1, fs1;
   logic [9:0] x1, y1;
   logic [23:0] rgb1;

   int n_chk = 0;
   int n_fail = 0;

   vga_timing_gen u_dut0 (
      .clk           (clk),
      .rstBtn        (rst0),
      .en            (en0),
      .pix_ce        (ce0),
      .x_o           (x0),
      .y_o           (y0),
      .hsync_o       (hs0),
      .vsync_o       (vs0),
      .blank_n_o     (bl0),
      .sync_n_o      (sn0),
      .line_start_o  (ls0),
      .frame_start_o (fs0),
      .rgb_o         (rgb0)
   );

   vga_timing_gen #(
      .CLK_DIV  (1),
      .H_ACTIVE (16),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (3),
      .V_ACTIVE (8),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3),
      .H_POL    (1'b1),
      .V_POL    (1'b0)
   ) u_dut1 (
      .clk           (clk),
      .rstBtn        (rst1),
      .en            (en1),
      .pix_ce        (ce1),
      .x_o           (x1),
      .y_o           (y1),
      .hsync_o       (hs1),
      .vsync_o       (vs1),
      .blank_n_o     (bl1),
      .sync_n_o      (sn1),
      .line_start_o  (ls1),
      .frame_start_o (fs1),
      .rgb_o         (rgb1)
   );

   typedef struct {
      int          p;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [4:0]  fl;
      logic [23:0] rgb;
   } vec_t;

   localparam int NV = 26;
   vec_t tv [NV];

   function automatic vec_t mk(input int p, input int x, input int y,
                               input logic [4:0] fl,
                               input logic [23:0] rgb);
      vec_t r;
      r.p   = p;
      r.x   = 10'(x);
      r.y   = 10'(y);
      r.fl  = fl;
      r.rgb = rgb;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int p, idx, nls1, nfs1, bad_ce1;
      int bad_ce0, bad_x0, hs_lo, hs_first, hs_last, bl_fall;
      int ls_a, ls_b, n_ls0, n_fs0, bad_hold;
      logic [23:0] er;

      // flags = {hsync, vsync, blank_n, line_start, frame_start}
      tv[0]  = mk(0,   0,  0,  5'b01111, 24'hFFFFFF);
      tv[1]  = mk(1,   1,  0,  5'b01100, 24'hFFFFFF);
      tv[2]  = mk(2,   2,  0,  5'b01100, 24'hFFFF00);
      tv[3]  = mk(4,   4,  0,  5'b01100, 24'h00FFFF);
      tv[4]  = mk(6,   6,  0,  5'b01100, 24'h00FF00);
      tv[5]  = mk(8,   8,  0,  5'b01100, 24'hFF00FF);
      tv[6]  = mk(10,  10, 0,  5'b01100, 24'hFF0000);
      tv[7]  = mk(12,  12, 0,  5'b01100, 24'h0000FF);
      tv[8]  = mk(15,  15, 0,  5'b01100, 24'h000000);
      tv[9]  = mk(16,  16, 0,  5'b01000, 24'h000000);
      tv[10] = mk(17,  17, 0,  5'b01000, 24'h000000);
      tv[11] = mk(18,  18, 0,  5'b11000, 24'h000000);
      tv[12] = mk(20,  20, 0,  5'b11000, 24'h000000);
      tv[13] = mk(21,  21, 0,  5'b01000, 24'h000000);
      tv[14] = mk(23,  23, 0,  5'b01000, 24'h000000);
      tv[15] = mk(24,  0,  1,  5'b01110, 24'hFFFFFF);
      tv[16] = mk(191, 23, 7,  5'b01000, 24'h000000);
      tv[17] = mk(192, 0,  8,  5'b01010, 24'h000000);
      tv[18] = mk(239, 23, 9,  5'b01000, 24'h000000);
      tv[19] = mk(240, 0,  10, 5'b00010, 24'h000000);
      tv[20] = mk(258, 18, 10, 5'b10000, 24'h000000);
      tv[21] = mk(264, 0,  11, 5'b00010, 24'h000000);
      tv[22] = mk(288, 0,  12, 5'b01010, 24'h000000);
      tv[23] = mk(359, 23, 14, 5'b01000, 24'h000000);
      tv[24] = mk(360, 0,  0,  5'b01111, 24'hFFFFFF);
      tv[25] = mk(366, 6,  0,  5'b01100, 24'h00FF00);

      rst0 = 1'b0;
      rst1 = 1'b0;
      en0  = 1'b1;
      en1  = 1'b1;
      #22;

      check("dut0_reset",
            64'({x0, y0, hs0, vs0, bl0, ls0, fs0, ce0, sn0}),
            64'({10'd799, 10'd524, 7'b1100000}));
      check("dut0_reset_rgb", 64'(rgb0), 64'd0);
      check("dut1_reset",
            64'({x1, y1, hs1, vs1, bl1, ls1, fs1, ce1, sn1}),
            64'({10'd23, 10'd14, 7'b0100000}));

      // ---------------- default instance ----------------
      bad_ce0 = 0; bad_x0 = 0; hs_lo = 0;
      hs_first = -1; hs_last = -1; bl_fall = -1;
      ls_a = -1; ls_b = -1; n_ls0 = 0; n_fs0 = 0;

      @(negedge clk);
      rst0 = 1'b1;
      for (int e = 1; e <= 2202; e++) begin
         @(posedge clk);
         #1;
         if (ce0 !== (e % 2 == 0))
            bad_ce0++;
         if (e == 1)
            check("dut0_no_ce_clk1", 64'({ce0, x0}),
                  64'({1'b0, 10'd799}));
         if (e == 2)
            check("dut0_first_pix",
                  64'({x0, y0, fs0, ls0, bl0, hs0, vs0}),
                  64'({10'd0, 10'd0, 5'b11111}));
         if (e % 2 == 0) begin
            p = (e - 2) / 2;
            if (x0 !== 10'(p % 800) || y0 !== 10'(p / 800))
               bad_x0++;
            if (p < 800) begin
               if (hs0 === 1'b0) begin
                  hs_lo++;
                  if (hs_first < 0)
                     hs_first = p;
                  hs_last = p;
               end
               if (bl0 === 1'b0 && bl_fall < 0)
                  bl_fall = p;
            end
         end
         if (ls0 === 1'b1) begin
            n_ls0++;
            if (ls_a < 0)
               ls_a = e;
            else if (ls_b < 0)
               ls_b = e;
         end
         if (fs0 === 1'b1)
            n_fs0++;
      end

      check("dut0_ce_pattern", 64'(bad_ce0), 64'd0);
      check("dut0_xy_sequence", 64'(bad_x0), 64'd0);
      check("dut0_hsync_width", 64'(hs_lo), 64'd96);
      check("dut0_hsync_first", 64'(hs_first), 64'd656);
      check("dut0_hsync_last", 64'(hs_last), 64'd751);
      check("dut0_blank_fall", 64'(bl_fall), 64'd640);
      check("dut0_line_period", 64'(ls_b - ls_a), 64'd1600);
      check("dut0_line_count", 64'(n_ls0), 64'd2);
      check("dut0_frame_count", 64'(n_fs0), 64'd1);
      check("dut0_at_300",
            64'({x0, y0, ce0, bl0, hs0}),
            64'({10'd300, 10'd1, 3'b111}));

      en0 = 1'b0;
      bad_hold = 0;
      for (int k = 0; k < 37; k++) begin
         @(posedge clk);
         #1;
         if (x0 !== 10'd300 || ce0 !== 1'b0 || ls0 !== 1'b0 ||
             fs0 !== 1'b0 || bl0 !== 1'b1 || hs0 !== 1'b1)
            bad_hold++;
      end
      check("dut0_en_hold", 64'(bad_hold), 64'd0);

      en0 = 1'b1;
      @(posedge clk);
      #1;
      check("dut0_resume_clk1", 64'({ce0, x0}), 64'({1'b0, 10'd300}));
      @(posedge clk);
      #1;
      check("dut0_resume_clk2", 64'({ce0, x0, y0}),
            64'({1'b1, 10'd301, 10'd1}));
      check("dut0_sync_n", 64'(sn0), 64'd0);
      rst0 = 1'b0;

      // ---------------- tiny-timing instance ----------------
      idx = 0; nls1 = 0; nfs1 = 0; bad_ce1 = 0;
      @(negedge clk);
      rst1 = 1'b1;
      for (int e = 1; e <= 501; e++) begin
         @(posedge clk);
         #1;
         p = e - 1;
         if (ce1 !== 1'b1)
            bad_ce1++;
         if (p <= 360) begin
            if (ls1 === 1'b1)
               nls1++;
            if (fs1 === 1'b1)
               nfs1++;
         end
         if (idx < NV && tv[idx].p == p) begin
`ifdef VGA_TEST_PATTERN_EN
            er = tv[idx].rgb;
`else
            er = 24'h0;
`endif
            check($sformatf("dut1_pix%0d", p),
                  64'({x1, y1, hs1, vs1, bl1, ls1, fs1}),
                  64'({tv[idx].x, tv[idx].y, tv[idx].fl}));
            check($sformatf("dut1_rgb%0d", p), 64'(rgb1), 64'(er));
            idx++;
         end
      end

      check("dut1_vectors_hit", 64'(idx), 64'(NV));
      check("dut1_ce_always", 64'(bad_ce1), 64'd0);
      check("dut1_line_starts", 64'(nls1), 64'd16);
      check("dut1_frame_starts", 64'(nfs1), 64'd2);
      check("dut1_mid_frame", 64'({x1, y1}),
            64'({10'd20, 10'd5}));

      #2;
      rst1 = 1'b0;
      #1;
      check("dut1_async_rst",
            64'({x1, y1, hs1, vs1, bl1, ls1, fs1, ce1, sn1}),
            64'({10'd23, 10'd14, 7'b0100000}));
      check("dut1_async_rst_rgb", 64'(rgb1), 64'd0);

      @(negedge clk);
      rst1 = 1'b1;
      @(posedge clk);
      #1;
`ifdef VGA_TEST_PATTERN_EN
      er = 24'hFFFFFF;
`else
      er = 24'h0;
`endif
      check("dut1_restart",
            64'({x1, y1, hs1, vs1, bl1, ls1, fs1, ce1}),
            64'({10'd0, 10'd0, 6'b011111}));
      check("dut1_restart_rgb", 64'(rgb1), 64'(er));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
